// File: rtl/array_west_feeder_pkg.sv
// Shared encodings for the west-edge feeder of the weight-stationary MAC array:
// per-row instruction codes, FSM states and lane slicing constants.
package array_west_feeder_pkg;

  localparam int INST_W = 2;

  localparam logic [INST_W-1:0] INST_IDLE = 2'b00;
  localparam logic [INST_W-1:0] INST_LOAD = 2'b01;
  localparam logic [INST_W-1:0] INST_EXEC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Only kernel load and execute produce waves; 00 and 11 complete empty.
  function automatic logic op_legal(input logic [INST_W-1:0] op);
    return (op == INST_LOAD) || (op == INST_EXEC);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain used to stagger one row's {inst, data} lane.
// depth = 0 degenerates to a wire.
module skew_delay_line #(
  parameter int depth = 1,
  parameter int width = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  generate
    if (depth == 0) begin : g_pass
      logic unused_clk_reset;
      assign unused_clk_reset = clk | reset;
      assign q = d;
    end else begin : g_chain
      logic [width-1:0] stage [depth];

      // NOTE: every stage is cleared on reset so an aborted wave never reaches
      // the array; non-blocking assignments let each stage take its neighbour's
      // old value, giving a true shift rather than a fall-through.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < depth; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < depth; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[depth-1];
    end
  endgenerate

endmodule

// File: rtl/array_west_feeder.sv
// West-edge feeder: accepts one command plus a vector stream and drives the
// array rows with diagonally skewed data and instructions, then flushes.
module array_west_feeder
  import array_west_feeder_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int len_bw = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [len_bw-1:0]     cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [row*bw-1:0]     in_data,
  output logic [row*bw-1:0]     out_w,
  output logic [row*INST_W-1:0] inst_w,
  output logic                  busy,
  output logic                  done
);

  localparam int STAGE_W = bw + INST_W;
  localparam int DRAIN_W = (row > 1) ? $clog2(row) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(row - 1);

  state_t              state, state_next;
  logic [INST_W-1:0]   op_q;
  logic [len_bw-1:0]   cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                cmd_fire, in_fire, last_fire, cmd_has_work;
  logic [INST_W-1:0]   inst0;
  logic [row*bw-1:0]   data0;

  assign cmd_fire     = cmd_valid & cmd_ready;
  assign in_fire      = in_valid & in_ready;
  assign last_fire    = in_fire && (cnt == len_bw'(1));
  assign cmd_has_work = op_legal(cmd_op) && (cmd_len != '0);

  // NOTE: every output and next-state value gets a default before the case so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_fire) state_next = cmd_has_work ? ST_RUN : ST_DRAIN;
      end
      ST_RUN: begin
        in_ready = (cnt != '0);
        if (last_fire) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Last vector is on the bottom row exactly row-1 cycles into DRAIN.
        done = (drain_cnt == DRAIN_LAST);
        if (done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_q      <= INST_IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      inst0     <= INST_IDLE;
      data0     <= '0;
    end else begin
      state <= state_next;

      if (cmd_fire) begin
        op_q      <= cmd_op;
        cnt       <= cmd_len;
        // Empty commands skip straight to the final drain cycle.
        drain_cnt <= cmd_has_work ? '0 : DRAIN_LAST;
      end else if (in_fire) begin
        cnt <= cnt - len_bw'(1);
      end else if (state == ST_DRAIN && !done) begin
        drain_cnt <= drain_cnt + DRAIN_W'(1);
      end

      // Any cycle without an accepted vector injects a bubble.
      inst0 <= in_fire ? op_q : INST_IDLE;
      data0 <= in_fire ? in_data : '0;
    end
  end

  for (genvar r = 0; r < row; r++) begin : g_row
    logic [STAGE_W-1:0] row_q;

    skew_delay_line #(
      .depth(r),
      .width(STAGE_W)
    ) u_skew (
      .clk  (clk),
      .reset(reset),
      .d    ({inst0, data0[r*bw +: bw]}),
      .q    (row_q)
    );

    assign inst_w[r*INST_W +: INST_W] = row_q[STAGE_W-1 -: INST_W];
    assign out_w[r*bw +: bw]          = row_q[bw-1:0];
  end

endmodule

// File: doc/array_west_feeder.md
Name: array_west_feeder

Overview:
- Drives the west edge of the weight-stationary systolic MAC array: per-row data lanes (in_w) and 2-bit instructions (inst_w, bit1 = execute, bit0 = kernel load).
- Takes one command (op + vector count) and a valid/ready stream of row-wide vectors.
- Applies the diagonal skew: row r sees each vector r cycles after row 0.
- Flushes the skew and reports completion, so the array receives correctly staggered kernel-load or execute waves.

Parameters:
- bw, 4, bits per data lane (activation/weight width, matches tile bw)
- row, 8, number of array rows driven
- len_bw, 8, width of the command vector count

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  2'b01 kernel load, 2'b10 execute; 00/11 illegal
- cmd_len  in  len_bw  number of vectors in this command
- in_valid  in  1  vector offered
- in_ready  out  1  vector accepted when in_valid & in_ready
- in_data  in  row*bw  lane r = bits [bw*(r+1)-1 : bw*r]
- out_w  out  row*bw  lane r drives in_w of row r, column 0 tile
- inst_w  out  row*2  bits [2r+1:2r] drive inst_w of row r
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous, low:
  - State goes to IDLE; all delay-line stages and the length counter clear.
  - Outputs: out_w = 0, inst_w = 0, done = 0, busy = 0, in_ready = 0, cmd_ready = 1.
  - Takes effect immediately mid-operation: in-flight skewed vectors are discarded, no done pulse.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On acceptance, op and len are latched and the counter is loaded with len.
  - If op is legal and len > 0, go to RUN. Otherwise go to DRAIN with nothing in flight: done pulses the next cycle and nothing is issued.
- RUN:
  - in_ready = 1 while counter > 0; cmd_ready = 0.
  - On an accepted vector:
    - Stage-0 register loads in_data with inst = the latched op.
    - The counter decrements.
    - When the counter reaches 0, go to DRAIN.
  - Any cycle in RUN without acceptance is a bubble: stage-0 loads data 0 with inst 2'b00, which the tile treats as no update.
- Skew:
  - Row r output = stage-0 delayed by r additional registers, with data and inst travelling together.
  - A vector accepted at edge t appears on row 0 in cycle t+1 and on row r in cycle t+1+r.
- DRAIN:
  - Stage-0 injects bubbles.
  - done = 1 in the cycle in which the last accepted vector appears on row row-1, i.e. t_last+row. State returns to IDLE at the end of that cycle.
  - cmd_ready rises in the following cycle. The minimum command-to-command gap is therefore one cycle after done.
- Ordering across commands: a load command and a subsequent execute never overlap in the skew chain, because the next command is accepted only after DRAIN. This guarantees kernel load completes in every row before execute begins.
- in_data is sampled only on acceptance. out_w lanes are 0 whenever the corresponding inst lane is 00.
- busy = (state != IDLE).
- Counter: len_bw bits, no wrap. cmd_len = 2^len_bw-1 is legal.

Decomposition:
- Shared package:
  - INST_IDLE = 2'b00, INST_LOAD = 2'b01, INST_EXEC = 2'b10
  - FSM state encoding (IDLE/RUN/DRAIN)
  - Lane slice helper constants
- One sub-module, skew_delay_line:
  - Parameters: depth, width.
  - Async active-low reset; a chain of depth registers.
  - Depth 0 is a pass-through.
  - Instantiated once per row with depth r, carrying {inst, data} of width bw+2.

Test Plan:
1. Exec, no bubbles: row=8, bw=4; cmd op=10, len=3; vectors 0x76543210, 0x89ABCDEF, 0x11111111, in_valid held high.
   - Row 0 shows lanes 0, F, 1 with inst 10 in cycles t0+1..t0+3.
   - Row 7 shows 7, 8, 1 in cycles t0+8..t0+10.
   - done = 1 at t0+10; cmd_ready = 1 at t0+11.
2. Bubbles: exec len=2 with in_valid low for 2 cycles between the vectors.
   - Every row shows vector A, then two cycles of inst 00 / data 0, then vector B, each staggered by r.
   - done aligns with B on row 7.
3. Kernel load then exec, issued back-to-back: load len=4 then exec len=2.
   - No cycle shows inst 01 on any row after the first inst 10 appears on row 0.
   - Two done pulses.
4. Zero/illegal: cmd len=0 op=10, then op=11 len=5.
   - Each gives done exactly one cycle after acceptance.
   - inst_w stays 0; in_ready never rises.
5. Reset mid-run: exec len=6, assert reset low after 3 vectors accepted (skew partially filled).
   - out_w = 0, inst_w = 0, busy = 0 immediately, with no clock edge needed.
   - No done pulse; after release, cmd_ready = 1 and a fresh len=1 command completes at t+8.
6. Handshake holdoff: cmd_valid held high during RUN and DRAIN.
   - cmd_ready = 0 throughout; the second command is accepted only in the cycle after done.
